// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator with start/busy/done handshake.
// Define EARLY_EXIT_EN to stop at the first differing bit; otherwise every compare takes WIDTH cycles.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             e,
    output logic             g,
    output logic             l
);

    localparam int unsigned    IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]  IDX_TOP = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb;
    logic [IW-1:0]    idx;
    logic             bit_gt, bit_lt, last_bit;
    logic             latch;
    logic             res_e, res_g, res_l;
`ifndef EARLY_EXIT_EN
    logic             diff_seen, diff_gt;
`endif

    // Operands shift left each compare cycle, so the current bit pair is always the MSB.
    assign bit_gt   = ra[WIDTH-1] & ~rb[WIDTH-1];
    assign bit_lt   = ~ra[WIDTH-1] & rb[WIDTH-1];
    assign last_bit = (idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        latch     = 1'b0;
        res_e     = 1'b0;
        res_g     = 1'b0;
        res_l     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = COMPARE;
            end
            COMPARE: begin
                busy = 1'b1;
`ifdef EARLY_EXIT_EN
                if (bit_gt) begin
                    latch = 1'b1;
                    res_g = 1'b1;
                end else if (bit_lt) begin
                    latch = 1'b1;
                    res_l = 1'b1;
                end else if (last_bit) begin
                    latch = 1'b1;
                    res_e = 1'b1;
                end
`else
                // The sticky flag holds the first difference; bit 0 decides only if none was seen.
                if (last_bit) begin
                    latch = 1'b1;
                    if (diff_seen) begin
                        res_g = diff_gt;
                        res_l = ~diff_gt;
                    end else if (bit_gt) begin
                        res_g = 1'b1;
                    end else if (bit_lt) begin
                        res_l = 1'b1;
                    end else begin
                        res_e = 1'b1;
                    end
                end
`endif
                if (latch) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra        <= '0;
            rb        <= '0;
            idx       <= IDX_TOP;
            e         <= 1'b0;
            g         <= 1'b0;
            l         <= 1'b0;
`ifndef EARLY_EXIT_EN
            diff_seen <= 1'b0;
            diff_gt   <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                ra        <= a;
                rb        <= b;
                idx       <= IDX_TOP;
`ifndef EARLY_EXIT_EN
                diff_seen <= 1'b0;
                diff_gt   <= 1'b0;
`endif
            end else if (state == COMPARE) begin
                ra  <= ra << 1;
                rb  <= rb << 1;
                idx <= idx - IW'(1);
`ifndef EARLY_EXIT_EN
                if (!diff_seen && (bit_gt || bit_lt)) begin
                    diff_seen <= 1'b1;
                    diff_gt   <= bit_gt;
                end
`endif
            end
            if (latch) begin
                e <= res_e;
                g <= res_g;
                l <= res_l;
            end
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator: WIDTH=8 directed tests plus a
// shared random sweep over WIDTH=1, 8 and 32 instances; honours EARLY_EXIT_EN.
module tb_serial_magnitude_comparator;

    typedef struct {
        logic [2:0]  egl;
        int unsigned dcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a_in, b_in;
    logic        busy1, done1, e1, g1, l1;
    logic        busy8, done8, e8, g8, l8;
    logic        busy32, done32, e32, g32, l32;

    int unsigned errors = 0;
    int unsigned checks = 0;

    exp_t        q8[$];
    exp_t        sq[3][$];
    logic        done_v[3];
    logic [2:0]  egl_v[3];
    int unsigned wv[3] = '{1, 8, 32};

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[0:0]), .b(b_in[0:0]),
        .busy(busy1), .done(done1), .e(e1), .g(g1), .l(l1));
    serial_magnitude_comparator #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[7:0]), .b(b_in[7:0]),
        .busy(busy8), .done(done8), .e(e8), .g(g8), .l(l8));
    serial_magnitude_comparator #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in),
        .busy(busy32), .done(done32), .e(e32), .g(g32), .l(l32));

    assign done_v[0] = done1;
    assign done_v[1] = done8;
    assign done_v[2] = done32;
    assign egl_v[0]  = {e1, g1, l1};
    assign egl_v[1]  = {e8, g8, l8};
    assign egl_v[2]  = {e32, g32, l32};

    // Reference: {e,g,l} from plain unsigned compare; done cycle = m + 1.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input int unsigned w);
        exp_t        r;
        logic [31:0] mask, x, y;
        int unsigned m;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x = av & mask;
        y = bv & mask;
        if (x > y)      r.egl = 3'b010;
        else if (x < y) r.egl = 3'b001;
        else            r.egl = 3'b100;
        m = w;
`ifdef EARLY_EXIT_EN
        for (int i = int'(w) - 1; i >= 0; i--) begin
            if (x[i] != y[i]) begin
                m = w - int unsigned'(i);
                break;
            end
        end
`endif
        r.dcyc = m + 1;
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy8, done8, e8, g8, l8} !== 5'b0) begin
            errors++;
            $display("FAIL reset_values: got %b expected 00000", {busy8, done8, e8, g8, l8});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, e8, g8, l8} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 00000", {busy8, done8, e8, g8, l8});
        end
    endtask

    task automatic run_cmp(input string name, input logic [31:0] av, input logic [31:0] bv,
                           input bit hold, input bit scramble);
        exp_t        ex;
        logic [2:0]  prev;
        int unsigned cyc;
        bit          seen, busy_ok, held_ok;
        prev = {e8, g8, l8};
        q8.push_back(model(av, bv, 8));
        @(negedge clk);
        start = 1'b1;
        a_in  = av;
        b_in  = bv;
        seen = 1'b0; busy_ok = 1'b1; held_ok = 1'b1; cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                seen = 1'b1;
            end else begin
                if (busy8 !== 1'b1) busy_ok = 1'b0;
                if ({e8, g8, l8} !== prev) held_ok = 1'b0;
            end
            if (!hold) start = 1'b0;
            if (scramble && !seen) begin
                a_in = $urandom;
                b_in = $urandom;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, cyc);
            void'(q8.pop_front());
            start = 1'b0;
            return;
        end
        ex = q8.pop_front();
        if (cyc !== ex.dcyc) begin
            errors++;
            $display("FAIL %s_latency: done in cycle %0d expected %0d", name, cyc, ex.dcyc);
        end
        checks++;
        if ({e8, g8, l8} !== ex.egl) begin
            errors++;
            $display("FAIL %s_result: egl=%b expected %b", name, {e8, g8, l8}, ex.egl);
        end
        checks++;
        if (!busy_ok || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: busy wrong during compare or %b in done cycle, expected 0", name, busy8);
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL %s_hold_prev: egl changed before done, expected %b", name, prev);
        end
        // start (if held) stays high through the DONE cycle and must not be accepted.
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy8, done8, e8, g8, l8} !== {2'b00, ex.egl}) begin
            errors++;
            $display("FAIL %s_after_done: busy,done,egl=%b expected %b", name,
                     {busy8, done8, e8, g8, l8}, {2'b00, ex.egl});
        end
    endtask

    task automatic test_back_to_back();
        exp_t        ex;
        int unsigned cyc;
        bit          seen;
        q8.push_back(model(32'hA5, 32'hA5, 8));
        q8.push_back(model(32'h01, 32'h02, 8));
        @(negedge clk);
        start = 1'b1;
        a_in  = 32'hA5;
        b_in  = 32'hA5;
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0; cyc = 0;
            while (!seen && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (done8) seen = 1'b1;
            end
            ex = q8.pop_front();
            checks++;
            if (!seen || cyc !== ex.dcyc || {e8, g8, l8} !== ex.egl) begin
                errors++;
                $display("FAIL b2b_%0d: done=%b cycle %0d egl=%b expected cycle %0d egl=%b",
                         k, seen, cyc, {e8, g8, l8}, ex.dcyc, ex.egl);
            end
            a_in = 32'h01;
            b_in = 32'h02;
            @(negedge clk);
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle_%0d: busy=%b done=%b expected 0 0", k, busy8, done8);
            end
            if (k == 1) start = 1'b0;
            // start held into this IDLE cycle is accepted at its closing edge
        end
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_extra: busy=%b done=%b expected 0 0", busy8, done8);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned extra;
        @(negedge clk);
        start = 1'b1;
        a_in  = 32'h12;
        b_in  = 32'h13;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, e8, g8, l8} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid: got %b expected 00000", {busy8, done8, e8, g8, l8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        checks++;
        if (extra != 0 || {e8, g8, l8} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_discard: %0d busy/done cycles egl=%b expected 0 and 000",
                     extra, {e8, g8, l8});
        end
    endtask

    task automatic test_random_sweep();
        logic [31:0] av, bv;
        bit          seen[3];
        int unsigned cyc;
        exp_t        ex;
        start = 1'b0;
        repeat (40) @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            av = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = av;
                1:       bv = av ^ (32'd1 << $urandom_range(0, 7));
                default: bv = $urandom;
            endcase
            for (int d = 0; d < 3; d++) begin
                sq[d].push_back(model(av, bv, wv[d]));
                seen[d] = 1'b0;
            end
            @(negedge clk);
            start = 1'b1;
            a_in  = av;
            b_in  = bv;
            cyc   = 0;
            while (!(seen[0] && seen[1] && seen[2]) && cyc < 40) begin
                @(negedge clk);
                cyc++;
                start = 1'b0;
                for (int d = 0; d < 3; d++) begin
                    if (done_v[d]) begin
                        checks++;
                        if (seen[d]) begin
                            errors++;
                            $display("FAIL sweep_w%0d_double_done: cycle %0d", wv[d], cyc);
                        end else begin
                            seen[d] = 1'b1;
                            ex = sq[d].pop_front();
                            if (cyc !== ex.dcyc || egl_v[d] !== ex.egl) begin
                                errors++;
                                $display("FAIL sweep_w%0d a=%h b=%h: cycle %0d egl=%b expected cycle %0d egl=%b",
                                         wv[d], av, bv, cyc, egl_v[d], ex.dcyc, ex.egl);
                            end
                        end
                    end
                end
            end
            for (int d = 0; d < 3; d++) begin
                if (!seen[d]) begin
                    checks++;
                    errors++;
                    $display("FAIL sweep_w%0d_timeout: a=%h b=%h no done", wv[d], av, bv);
                    if (sq[d].size() > 0) void'(sq[d].pop_front());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        run_cmp("equal_a5", 32'hA5, 32'hA5, 1'b0, 1'b0);
        run_cmp("gt_80_7f", 32'h80, 32'h7F, 1'b0, 1'b0);
        run_cmp("lt_12_13", 32'h12, 32'h13, 1'b0, 1'b0);
        run_cmp("hold_scramble", 32'h5A, 32'h59, 1'b1, 1'b1);
        test_back_to_back();
        test_reset_mid();
        run_cmp("after_reset", 32'h3C, 32'hC3, 1'b0, 1'b0);
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
